// File: rtl/id_stage.sv
// Pipelined MIPS R3000 decode stage: full-word decode, load-use bubbling, flush, bubble counter.
// Define ID_ILLEGAL_TRAP_EN to flag unknown opcodes and stall after one retires until flush.
module id_stage #(
  parameter int IW    = 32,
  parameter int XLEN  = 32,
  parameter int RAW   = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IW-1:0]    in_instr,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       alu_op,
  output logic             source_1_sel,
  output logic             branch,
  output logic             jump,
  output logic             load,
  output logic             store,
  output logic             mem_rd_en,
  output logic             mem_wr_en,
  output logic [3:0]       branch_control,
  output logic [RAW-1:0]   rs,
  output logic [RAW-1:0]   rt,
  output logic [RAW-1:0]   dest,
  output logic [XLEN-1:0]  imm,
  output logic [25:0]      jtarget,
  output logic             illegal,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [5:0] {
    OP_R    = 6'b000000,
    OP_J    = 6'b000010,
    OP_BEQ  = 6'b000100,
    OP_BNE  = 6'b000101,
    OP_BGT  = 6'b000111,
    OP_ADDI = 6'b001000,
    OP_SLTI = 6'b001010,
    OP_ANDI = 6'b001100,
    OP_ORI  = 6'b001101,
    OP_XORI = 6'b001110,
    OP_LW   = 6'b100101,
    OP_SW   = 6'b101011
  } opcode_e;

  typedef struct packed {
    logic [5:0]      alu_op;
    logic            source_1_sel;
    logic            branch;
    logic            jump;
    logic            load;
    logic            store;
    logic            mem_rd_en;
    logic            mem_wr_en;
    logic [3:0]      branch_control;
    logic [RAW-1:0]  rs;
    logic [RAW-1:0]  rt;
    logic [RAW-1:0]  dest;
    logic [XLEN-1:0] imm;
    logic [25:0]     jtarget;
    logic            illegal;
  } bundle_t;

  logic [5:0] opcode;
  bundle_t    dec;
  bundle_t    out_q;
  logic       uses_rs;
  logic       uses_rt;
  logic       hazard;
  logic       accept;
  logic       trap_hold;

  assign opcode = in_instr[IW-1 -: 6];

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    dec         = '0;
    dec.rs      = RAW'(in_instr[25:21]);
    dec.rt      = RAW'(in_instr[20:16]);
    dec.imm     = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
    dec.jtarget = in_instr[25:0];
    uses_rs     = 1'b1;
    uses_rt     = 1'b0;
    case (opcode)
      OP_R: begin
        dec.alu_op = 6'b100000;
        dec.dest   = RAW'(in_instr[15:11]);
        uses_rt    = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_XORI: begin
        dec.source_1_sel = 1'b1;
        dec.dest         = dec.rt;
        case (opcode)
          OP_ADDI: dec.alu_op = 6'b000001;
          OP_ANDI: dec.alu_op = 6'b000010;
          OP_ORI:  dec.alu_op = 6'b000100;
          OP_SLTI: dec.alu_op = 6'b001000;
          default: dec.alu_op = 6'b010000;
        endcase
      end
      OP_LW: begin
        dec.alu_op       = 6'b000001;
        dec.source_1_sel = 1'b1;
        dec.load         = 1'b1;
        dec.mem_rd_en    = 1'b1;
        dec.dest         = dec.rt;
      end
      OP_SW: begin
        dec.alu_op       = 6'b000001;
        dec.source_1_sel = 1'b1;
        dec.store        = 1'b1;
        dec.mem_wr_en    = 1'b1;
        uses_rt          = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BGT: begin
        dec.branch = 1'b1;
        uses_rt    = 1'b1;
        case (opcode)
          OP_BEQ:  dec.branch_control = 4'b0001;
          OP_BNE:  dec.branch_control = 4'b0010;
          default: dec.branch_control = 4'b0100;
        endcase
      end
      OP_J: begin
        dec.jump = 1'b1;
        uses_rs  = 1'b0;
      end
      default: begin
`ifdef ID_ILLEGAL_TRAP_EN
        dec.illegal = 1'b1;
`endif
      end
    endcase
  end

  // One bubble suffices: execute forwards from the load's write-back a cycle later.
  assign hazard = out_valid && out_q.load && (out_q.dest != '0) && in_valid &&
                  ((uses_rs && dec.rs == out_q.dest) || (uses_rt && dec.rt == out_q.dest));

  assign in_ready = !flush && !hazard && (!out_valid || out_ready) && !trap_hold;
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data fields are reset too, since they are visible outputs with defined reset values.
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_q     <= dec;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (hazard && out_ready && !flush && bubble_cnt != '1) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

`ifdef ID_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_hold <= 1'b0;
    end else if (flush) begin
      trap_hold <= 1'b0;
    end else if (out_valid && out_ready && out_q.illegal) begin
      trap_hold <= 1'b1;
    end
  end
`else
  assign trap_hold = 1'b0;
`endif

  assign alu_op         = out_q.alu_op;
  assign source_1_sel   = out_q.source_1_sel;
  assign branch         = out_q.branch;
  assign jump           = out_q.jump;
  assign load           = out_q.load;
  assign store          = out_q.store;
  assign mem_rd_en      = out_q.mem_rd_en;
  assign mem_wr_en      = out_q.mem_wr_en;
  assign branch_control = out_q.branch_control;
  assign rs             = out_q.rs;
  assign rt             = out_q.rt;
  assign dest           = out_q.dest;
  assign imm            = out_q.imm;
  assign jtarget        = out_q.jtarget;
  assign illegal        = out_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed instructions with hand-decoded expected bundles.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  alu_op;
  logic        source_1_sel, branch, jump, load, store, mem_rd_en, mem_wr_en;
  logic [3:0]  branch_control;
  logic [4:0]  rs, rt, dest;
  logic [31:0] imm;
  logic [25:0] jtarget;
  logic        illegal;
  logic [15:0] bubble_cnt;

`ifdef ID_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [5:0]  alu;
    logic [6:0]  ctl;  // source_1_sel, branch, jump, load, store, mem_rd_en, mem_wr_en
    logic [3:0]  bc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [25:0] jt;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t act;
  int   n_vec = 0;
  int   n_bad = 0;

  id_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
    .source_1_sel(source_1_sel), .branch(branch), .jump(jump), .load(load), .store(store),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .branch_control(branch_control),
    .rs(rs), .rt(rt), .dest(dest), .imm(imm), .jtarget(jtarget), .illegal(illegal),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  assign act = {alu_op, source_1_sel, branch, jump, load, store, mem_rd_en, mem_wr_en,
                branch_control, rs, rt, dest, imm, jtarget, illegal};

  function automatic exp_t mk(input logic [5:0] alu, input logic [6:0] ctl, input logic [3:0] bc,
                              input logic [4:0] rs_f, input logic [4:0] rt_f, input logic [4:0] dst,
                              input logic [31:0] imm_f, input logic [25:0] jt, input logic ill);
    mk = {alu, ctl, bc, rs_f, rt_f, dst, imm_f, jt, ill};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: every retired bundle must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      check("sb_has_entry", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("retire", 128'(act), 128'(e));
      end
    end
  end

  task automatic send(input logic [31:0] instr, input exp_t e, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    in_instr = instr;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 100) break;
    end
    if (in_ready) begin
      @(posedge clk);
      sb.push_back(e);
      #1;
    end else begin
      check("send_timeout", 128'(in_ready), 128'(1));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e_addi, e_lw, e_andi, e_ill;
    int   w;
    e_addi = mk(6'b000001, 7'b1000000, 4'b0000, 5'd0, 5'd1, 5'd1, 32'hFFFFFFFF, 26'h001FFFF, 1'b0);
    e_lw   = mk(6'b000001, 7'b1001010, 4'b0000, 5'd1, 5'd2, 5'd2, 32'h00000004, 26'h0220004, 1'b0);
    e_andi = mk(6'b000010, 7'b1000000, 4'b0000, 5'd3, 5'd2, 5'd2, 32'h000000FF, 26'h06200FF, 1'b0);
    e_ill  = mk(6'b000000, 7'b0000000, 4'b0000, 5'd1, 5'd2, 5'd0, 32'h00001234, 26'h0221234, TRAP);

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_bundle", 128'(act), 128'(0));
    check("reset_bubble_cnt", 128'(bubble_cnt), 128'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic ADDI, then load-use hazard through rs.
    send(32'h2001FFFF, e_addi, w);
    check("addi_wait", 128'(w), 128'(0));
    send(32'h94220004, e_lw, w);
    send(32'h00441820, mk(6'b100000, 7'b0000000, 4'b0000, 5'd2, 5'd4, 5'd3, 32'h00001820, 26'h0441820, 1'b0), w);
    check("hazard_wait", 128'(w), 128'(1));
    check("bubble_cnt_1", 128'(bubble_cnt), 128'(1));

    // Load to $0 never creates a hazard.
    send(32'h94200008, mk(6'b000001, 7'b1001010, 4'b0000, 5'd1, 5'd0, 5'd0, 32'h00000008, 26'h0200008, 1'b0), w);
    send(32'h00002820, mk(6'b100000, 7'b0000000, 4'b0000, 5'd0, 5'd0, 5'd5, 32'h00002820, 26'h0002820, 1'b0), w);
    check("ld_r0_wait", 128'(w), 128'(0));
    check("ld_r0_bubble_cnt", 128'(bubble_cnt), 128'(1));
    @(posedge clk);
    #1;

    // Backpressure: four ops, out_ready low for three cycles.
    out_ready = 1'b0;
    send(32'h306200FF, e_andi, w);
    fork
      begin
        int wb;
        send(32'h34858000, mk(6'b000100, 7'b1000000, 4'b0000, 5'd4, 5'd5, 5'd5, 32'hFFFF8000, 26'h0858000, 1'b0), wb);
        check("bp_wait", 128'(wb), 128'(3));
        send(32'h28C70010, mk(6'b001000, 7'b1000000, 4'b0000, 5'd6, 5'd7, 5'd7, 32'h00000010, 26'h0C70010, 1'b0), wb);
        send(32'h39091234, mk(6'b010000, 7'b1000000, 4'b0000, 5'd8, 5'd9, 5'd9, 32'h00001234, 26'h1091234, 1'b0), wb);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_in_ready", 128'(in_ready), 128'(0));
          check("bp_hold", 128'({out_valid, act}), 128'({1'b1, e_andi}));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join

    // Store, J ignoring rs, and a load-use hazard through rt.
    send(32'hAC43FFFC, mk(6'b000001, 7'b1000101, 4'b0000, 5'd2, 5'd3, 5'd0, 32'hFFFFFFFC, 26'h043FFFC, 1'b0), w);
    send(32'h94010000, mk(6'b000001, 7'b1001010, 4'b0000, 5'd0, 5'd1, 5'd1, 32'h00000000, 26'h0010000, 1'b0), w);
    send(32'h08200100, mk(6'b000000, 7'b0010000, 4'b0000, 5'd1, 5'd0, 5'd0, 32'h00000100, 26'h0200100, 1'b0), w);
    check("j_no_rs_use", 128'(w), 128'(0));
    send(32'h94220004, e_lw, w);
    send(32'h14220003, mk(6'b000000, 7'b0100000, 4'b0010, 5'd1, 5'd2, 5'd0, 32'h00000003, 26'h0220003, 1'b0), w);
    check("rt_hazard_wait", 128'(w), 128'(1));
    check("bubble_cnt_2", 128'(bubble_cnt), 128'(2));
    send(32'h1C64FFFE, mk(6'b000000, 7'b0100000, 4'b0100, 5'd3, 5'd4, 5'd0, 32'hFFFFFFFE, 26'h064FFFE, 1'b0), w);
    @(posedge clk);
    #1;
    check("drain_1", 128'(sb.size()), 128'(0));

    // Flush a registered BEQ while fetch offers ADDI.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h10210002;
    @(posedge clk);
    #1;
    in_instr = 32'h2001FFFF;
    flush    = 1'b1;
    @(negedge clk);
    check("beq_held", 128'({out_valid, branch_control}), 128'({1'b1, 4'b0001}));
    check("flush_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", 128'(out_valid), 128'(0));
    repeat (2) @(posedge clk);
    #1;

    // Unknown opcode 111111.
    send(32'hFC221234, e_ill, w);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ill_in_ready", 128'(in_ready), 128'(!TRAP));
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("ill_release", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    send(32'h2001FFFF, e_addi, w);
    check("ill_after_wait", 128'(w), 128'(0));
    @(posedge clk);
    #1;
    check("drain_2", 128'(sb.size()), 128'(0));

    // Asynchronous reset with an instruction registered and one offered.
    out_ready = 1'b0;
    send(32'h94220004, e_lw, w);
    in_valid = 1'b1;
    in_instr = 32'h2001FFFF;
    #2 rst = 1'b1;
    #1;
    check("rst_async", 128'({out_valid, act, bubble_cnt}), 128'(0));
    @(posedge clk);
    #1;
    check("rst_no_accept", 128'(out_valid), 128'(0));
    sb.delete();
    rst      = 1'b0;
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Pipelined, parametrised instruction-decode stage for the MIPS R3000 core. It sits between fetch and execute and decodes the full instruction word into the existing control bundle (alu_op, source_1_sel, branch, jump, load, store, mem_rd_en, mem_wr_en, branch_control). It also extracts register and immediate fields and registers the result behind a valid/ready handshake. It adds what the purely combinational decoder lacks: load-use hazard bubbling, flush, a bubble counter and optional illegal-opcode trapping.

## Interface
Parameters:
- IW, 32: instruction width; opcode is [IW-1:IW-6]
- XLEN, 32: sign-extended immediate width
- RAW, 5: register address width
- CNT_W, 16: bubble counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  fetch presents instruction
- in_instr  in  IW  instruction word
- in_ready  out  1  stage accepts in_instr this cycle (combinational)
- flush  in  1  discard the registered instruction, accept nothing this cycle
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute consumes bundle
- alu_op  out  6  R=100000, ADDI/LW/SW=000001, ANDI=000010, ORI=000100, SLTI=001000, XORI=010000, else 0
- source_1_sel, branch, jump, load, store, mem_rd_en, mem_wr_en  out  1 each  control bits, same meaning as the existing decoder
- branch_control  out  4  BEQ=0001, BNE=0010, BGT=0100, else 0000
- rs, rt, dest  out  RAW each  dest = rd for R-type, rt for ADDI/ANDI/ORI/SLTI/XORI/LW, 0 otherwise
- imm  out  XLEN  sign-extended instr[15:0]
- jtarget  out  26  instr[25:0]
- illegal  out  1  opcode not in table (ID_ILLEGAL_TRAP_EN only, else tied 0)
- bubble_cnt  out  CNT_W  count of hazard bubbles, saturating

## Operation
- Opcode table: 000000 R, 001000 ADDI, 001100 ANDI, 000100 BEQ, 000111 BGT, 000101 BNE, 100101 LW, 001101 ORI, 001010 SLTI, 101011 SW, 001110 XORI, 000010 J.
- source_1_sel=1 for all I-type ALU ops, LW and SW. branch=1 for BEQ/BNE/BGT. jump=1 for J. LW sets load and mem_rd_en. SW sets store and mem_wr_en.
- Single output register holding the decoded bundle plus out_valid.
- Uses: rs for every opcode except J. rt is also used for R-type, BEQ, BNE, BGT and SW.
- hazard = out_valid & load & (dest != 0) & in_valid & (incoming uses dest).
- in_ready = !flush & !hazard & (!out_valid | out_ready).
- Accept (in_valid & in_ready): the register loads the decoded in_instr and out_valid is 1 next cycle.
- Output fires without accept: out_valid goes to 0 next cycle.
- Neither: the register holds and all outputs remain stable while out_valid & !out_ready.
- Hazard with out_ready=1: the load retires and one bubble follows (out_valid=0 for one cycle). The dependent instruction is accepted the next cycle. bubble_cnt increments once per such cycle and saturates at all-ones.
- flush: out_valid=0 next cycle, no accept that cycle. flush has priority over in_valid, hazard and out_ready. Registered fields may hold stale values when out_valid=0.
- Unknown opcode without the macro: all control bits, alu_op and branch_control are 0 (NOP). Fields are still extracted.

## Timing
- Latency 1 cycle from accept to out_valid.
- Throughput 1 instruction per cycle absent hazard or backpressure.
- in_ready is combinational from in_valid, in_instr, flush, out_ready and state. It has no path from itself.
- Reset (asynchronous assert): out_valid=0, all control outputs 0, rs/rt/dest/imm/jtarget=0, illegal=0, bubble_cnt=0.
- Reset asserted mid-transfer: the registered instruction is lost and nothing is accepted while rst=1.
- Hazard requires only one bubble, because execute forwards from the load's write-back one cycle later.

## Configuration
- ID_ILLEGAL_TRAP_EN defined:
  - unknown opcodes decode to NOP controls with illegal=1 registered alongside them
  - after an illegal instruction fires, in_ready is held 0 until flush is asserted
- Not defined: illegal is constant 0 and unknown opcodes pass as NOPs with no stall.

## Test plan
- Reset, then ADDI 0x2001FFFF with out_ready=1 -> next cycle out_valid=1, alu_op=000001, source_1_sel=1, dest=1, imm=0xFFFFFFFF.
- LW 0x94220004 then ADD rd=3, rs=2, rt=4, back-to-back -> LW fires, one cycle out_valid=0, ADD fires the following cycle, bubble_cnt=1.
- LW to $0 followed by a use of $0 -> no bubble, bubble_cnt unchanged.
- Stream of 4 ops with out_ready=0 for 3 cycles -> outputs stable and in_ready=0 throughout, then all 4 retire in order with none dropped.
- flush asserted together with in_valid while BEQ is registered -> out_valid=0 next cycle, in_instr not accepted, branch_control=0001 never fires.
- With ID_ILLEGAL_TRAP_EN, opcode 111111 -> illegal=1, controls 0, in_ready=0 until flush. Without the macro, the same opcode retires as a NOP.
